// File: rtl/seg_pkg.sv
// Shared definitions for the segment scan controller: glyph constants,
// conversion FSM states and the digit nibble type.
package seg_pkg;

   typedef logic [3:0] nibble_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } conv_state_t;

   // Active-high glyphs: bit7=a .. bit1=g, bit0=dp (dp never lit)
   localparam logic [7:0] SEG_0     = 8'hfc;
   localparam logic [7:0] SEG_1     = 8'h60;
   localparam logic [7:0] SEG_2     = 8'hda;
   localparam logic [7:0] SEG_3     = 8'hf2;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'hb6;
   localparam logic [7:0] SEG_6     = 8'hbe;
   localparam logic [7:0] SEG_7     = 8'he0;
   localparam logic [7:0] SEG_8     = 8'hfe;
   localparam logic [7:0] SEG_9     = 8'hf6;
   localparam logic [7:0] SEG_A     = 8'hee;
   localparam logic [7:0] SEG_B     = 8'h3e;
   localparam logic [7:0] SEG_C     = 8'h9c;
   localparam logic [7:0] SEG_D     = 8'h7a;
   localparam logic [7:0] SEG_E     = 8'h9e;
   localparam logic [7:0] SEG_F     = 8'h8e;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   // Nibble to glyph; BCD digits and hex nibbles share one table
   function automatic logic [7:0] seg_glyph(input nibble_t n);
      case (n)
         4'h0: seg_glyph = SEG_0;
         4'h1: seg_glyph = SEG_1;
         4'h2: seg_glyph = SEG_2;
         4'h3: seg_glyph = SEG_3;
         4'h4: seg_glyph = SEG_4;
         4'h5: seg_glyph = SEG_5;
         4'h6: seg_glyph = SEG_6;
         4'h7: seg_glyph = SEG_7;
         4'h8: seg_glyph = SEG_8;
         4'h9: seg_glyph = SEG_9;
         4'ha: seg_glyph = SEG_A;
         4'hb: seg_glyph = SEG_B;
         4'hc: seg_glyph = SEG_C;
         4'hd: seg_glyph = SEG_D;
         4'he: seg_glyph = SEG_E;
         default: seg_glyph = SEG_F;
      endcase
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock.
// Handshake: start is honoured only while busy=0; busy rises the cycle after
// an accepted start and falls after the single COMMIT cycle, during which
// done=1 and value holds the result (BCD, or raw nibbles in hex mode).
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int NUM_W  = 24,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [NUM_W-1:0]      num,
   input  logic                  hex_mode,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [DIGITS*4-1:0]   value
);

   localparam int BCD_W = DIGITS * 4;
   localparam int CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;
   localparam int HEX_W = (NUM_W < BCD_W) ? NUM_W : BCD_W;

   conv_state_t       state;
   logic [NUM_W-1:0]  num_r;
   logic              hex_r;
   logic [BCD_W-1:0]  bcd;
   logic [BCD_W-1:0]  adj;
   logic [BCD_W-1:0]  hex_val;
   logic [CNT_W-1:0]  cnt;

   // Add-3 correction of every BCD digit ahead of the shift; hex nibbles are
   // the latched value zero-extended or truncated to the display width
   always_comb begin
      adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
      end
      hex_val = BCD_W'(num_r[HEX_W-1:0]);
   end

   assign done  = (state == COMMIT);
   assign value = hex_r ? hex_val : bcd;

   // Conversion FSM: IDLE -> SHIFT (NUM_W cycles) or straight to COMMIT -> IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         num_r <= '0;
         hex_r <= 1'b0;
         bcd   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  num_r <= num;
                  hex_r <= hex_mode;
                  bcd   <= '0;
                  cnt   <= '0;
                  ovf   <= 1'b0;
                  busy  <= 1'b1;
                  state <= hex_mode ? COMMIT : SHIFT;
               end
            end
            SHIFT: begin
               bcd   <= {adj[BCD_W-2:0], num_r[NUM_W-1]};
               num_r <= num_r << 1;
               // a bit leaving the top digit means the value does not fit
               if (adj[BCD_W-1]) ovf <= 1'b1;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(NUM_W - 1)) state <= COMMIT;
            end
            COMMIT: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment driver: converts a loaded value to BCD (or shows raw
// hex nibbles) and scans DIGITS digits across two segment banks; digits
// below DIGITS/2 drive seg1, the rest drive seg.
// Optional blinking of selected digits is built when SEG_SCAN_BLINK_EN is
// defined (adds blink_mask input and BLINK_DIV parameter, in scan frames).
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_W       = 24,
   parameter int DIGITS      = 8,
   parameter int REFRESH_DIV = 50000
`ifdef SEG_SCAN_BLINK_EN
   ,
   parameter int BLINK_DIV   = 256
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [NUM_W-1:0]    num,
   input  logic                hex_mode,
   input  logic                blank_lz,
   input  logic                enable,
`ifdef SEG_SCAN_BLINK_EN
   input  logic [DIGITS-1:0]   blink_mask,
`endif
   output logic                busy,
   output logic                ovf,
   output logic [7:0]          seg,
   output logic [7:0]          seg1,
   output logic [DIGITS-1:0]   an
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = $clog2(REFRESH_DIV);

   logic [DIGITS*4-1:0] disp;
   logic [DIGITS*4-1:0] conv_value;
   logic                conv_done;
   logic [CNT_W-1:0]    rcnt;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    next_idx;
   logic                slot_end;
   logic                frame_end;
   logic                blink_off;
   logic                lz_keep;
   nibble_t             cur_nib;
   logic [7:0]          glyph;

   bin2bcd_seq #(.NUM_W(NUM_W), .DIGITS(DIGITS)) u_conv (
      .clk      (clk),
      .rst      (rst),
      .start    (load),
      .num      (num),
      .hex_mode (hex_mode),
      .busy     (busy),
      .done     (conv_done),
      .ovf      (ovf),
      .value    (conv_value)
   );

   // Display register takes the converter result on its commit cycle
   always_ff @(posedge clk) begin
      if (rst) disp <= '0;
      else if (conv_done) disp <= conv_value;
   end

   assign slot_end  = (rcnt == CNT_W'(REFRESH_DIV - 1));
   assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));
   assign next_idx  = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;

   // Refresh divider and digit index; anode select moves with the index
   always_ff @(posedge clk) begin
      if (rst) begin
         rcnt <= '0;
         idx  <= '0;
         an   <= DIGITS'(1);
      end else if (slot_end) begin
         rcnt <= '0;
         idx  <= next_idx;
         an   <= DIGITS'(1) << next_idx;
      end else begin
         rcnt <= rcnt + 1'b1;
      end
   end

`ifdef SEG_SCAN_BLINK_EN
   localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   logic [BL_W-1:0] blink_cnt;
   logic            blink_phase;

   // Blink phase toggles once every BLINK_DIV complete scan frames
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_end) begin
         if (blink_cnt == BL_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   assign blink_off = blink_phase && blink_mask[idx];
`else
   assign blink_off = 1'b0;
`endif

   // Glyph for the current digit, with leading-zero, enable and blink blanking
   always_comb begin
      cur_nib = disp[int'(idx)*4 +: 4];
      lz_keep = (idx == '0);
      for (int i = 0; i < DIGITS; i++) begin
         if (i >= int'(idx) && disp[i*4 +: 4] != 4'h0) lz_keep = 1'b1;
      end
      glyph = (enable && (!blank_lz || lz_keep) && !blink_off) ? seg_glyph(cur_nib) : SEG_BLANK;
   end

   // Bank outputs registered one cycle after the index; idle bank is dark
   always_ff @(posedge clk) begin
      if (rst) begin
         seg  <= SEG_BLANK;
         seg1 <= SEG_BLANK;
      end else if (int'(idx) < DIGITS / 2) begin
         seg1 <= glyph;
         seg  <= SEG_BLANK;
      end else begin
         seg1 <= SEG_BLANK;
         seg  <= glyph;
      end
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised successor to the board's 7-segment scan driver: latches a binary value on a load handshake, converts it to BCD with a sequential double-dabble (one bit per clock), and time-multiplexes DIGITS digits across the two segment banks.
- Adds hex/decimal mode, leading-zero blanking, a busy/overflow status and a configurable refresh rate.
- Sits between the CPU's MMIO display register and the board pins.

Parameters:
- NUM_W, 24, width of the binary input value.
- DIGITS, 8, number of scanned digits (even, 2..8); digits 0..DIGITS/2-1 on seg1, the rest on seg.
- REFRESH_DIV, 50000, clk cycles per digit slot (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  one-cycle request to latch num/hex_mode; accepted only when busy=0.
- num  input  NUM_W  binary value.
- hex_mode  input  1  1 = show raw hex nibbles, 0 = decimal.
- blank_lz  input  1  1 = blank leading zeros.
- enable  input  1  0 = all digits blank; scanning continues.
- busy  output  1  conversion in progress.
- ovf  output  1  decimal value exceeded 10^DIGITS-1 (sticky until next accepted load).
- seg  output  8  upper-bank glyph, active-high, bit7=a .. bit1=g, bit0=dp (dp always 0).
- seg1  output  8  lower-bank glyph, same encoding.
- an  output  DIGITS  one-hot active-high digit select.

Behaviour:
- Reset: busy=0, ovf=0, seg=seg1=8'h00, an=1 (digit 0), scan index=0, refresh counter=0, display register=0, FSM=IDLE.
- Glyphs: 0 fc, 1 60, 2 da, 3 f2, 4 66, 5 b6, 6 be, 7 e0, 8 fe, 9 f6, A ee, b 3e, C 9c, d 7a, E 9e, F 8e; blank = 00.
- FSM IDLE -> SHIFT or COMMIT -> IDLE:
  - IDLE: load=1 latches num/hex_mode, clears ovf, busy=1 next cycle; goes to COMMIT if hex_mode else SHIFT.
  - SHIFT: exactly NUM_W cycles. Each cycle every 4-bit digit >=5 gets +3, then the whole register shifts left taking the next num bit, MSB first. Bits shifted out of the top digit set ovf.
  - COMMIT: 1 cycle; writes the display register (BCD, or num nibbles zero-extended/truncated to DIGITS), then busy=0.
- Latency, load to display-register update: decimal NUM_W+1 cycles; hex 1 cycle. busy is high for exactly that many cycles.
- load while busy=1 is ignored with no queueing. load held high re-triggers on the first idle cycle.
- Hex mode never sets ovf. Nibbles above DIGITS are dropped silently.
- Scan: refresh counter runs 0..REFRESH_DIV-1. At the terminal count the index advances and wraps DIGITS-1 -> 0, and an updates the same cycle as the index. seg/seg1 are registered from the new index 1 cycle later.
- The bank not owning the current index outputs 8'h00.
- Leading-zero blank: with blank_lz=1, digits above the highest non-zero digit show 00; digit 0 always shows.
- enable=0 forces both banks to 00 and does not stop the scan.
- rst mid-conversion aborts to IDLE, and the display register is zeroed.

Optional Feature:
- SEG_SCAN_BLINK_EN defined:
  - Adds input blink_mask[DIGITS-1:0] and parameter BLINK_DIV (default 256, in full scan frames).
  - A blink phase bit toggles every BLINK_DIV frames; it resets to 0.
  - While phase=1, masked digits show 00.
- Undefined: no port, no counter, blink logic absent, behaviour identical to phase=0.

Decomposition:
- Package seg_pkg: glyph constants (SEG_0..SEG_F, SEG_BLANK), FSM state enum (IDLE, SHIFT, COMMIT), digit-nibble typedef.
- Sub-module bin2bcd_seq: the sequential double-dabble with start/busy/done/ovf. The top holds the scan, blanking and bank split.

Test Plan:
- DIGITS=8, REFRESH_DIV=4: load num=123456 decimal, blank_lz=1 -> busy high 25 cycles. Then the scan gives seg1=be,b6,66,f2 on an=01,02,04,08; seg=da,60,00,00 on an=10,20,40,80; ovf=0.
- hex_mode=1, num=24'hABCDEF, blank_lz=0 -> busy 1 cycle. Digit0 seg1=8e, digit5 seg=ee, digits 6,7 seg=fc.
- DIGITS=4: load 12345 decimal -> ovf=1, digits 3..0 show 2,3,4,5 (da,f2,66,b6). Next load of 7 clears ovf.
- Second load pulse at cycle 5 of a decimal conversion -> ignored; the display shows the first value.
- rst asserted mid-SHIFT -> next cycle busy=0, an=1, seg=seg1=00. enable=0 -> an keeps scanning, both banks 00.
- SEG_SCAN_BLINK_EN, BLINK_DIV=2, blink_mask=8'h01 -> digit 0 alternates glyph/00 every 2 frames.
